// File: rtl/sonic_echo_emu.sv
// Ultrasonic ranging sensor emulator: validates a trigger pulse, waits out the burst, then answers with an echo pulse.
// Optional build macro SONIC_ECHO_EMU_NOISE_EN adds 0..7 us of LFSR jitter to every echo width.
module sonic_echo_emu #(
    parameter int CLK_PER_US  = 100,
    parameter int MIN_TRIG_US = 10,
    parameter int BURST_US    = 200,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] dist_cm,
    output logic       echo,
    output logic       busy,
    output logic       meas_done,
    output logic       trig_err
);

    localparam int            PW         = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_PER_US - 1);
    localparam logic [15:0]   MIN_US     = 16'(MIN_TRIG_US);
    localparam logic [15:0]   MIN_US_M1  = 16'(MIN_TRIG_US - 1);
    localparam logic [15:0]   BURST_LAST = 16'(BURST_US - 1);
    localparam logic [15:0]   HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]   TIMEOUT_W  = 16'(TIMEOUT_US);
    localparam logic [8:0]    MAX_D      = 9'(MAX_CM);

    typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

    state_t        state, state_n;
    logic          trig_s1, trig_s, trig_d;
    logic [1:0]    sync_fill;
    logic          armed;
    logic [PW-1:0] pre_cnt;
    logic [15:0]   us_cnt;
    logic [8:0]    dist_q;
    logic [15:0]   base_w, width_us;
    logic          rise, fall, pre_wrap, trig_long, accept;

    // A rise only counts once the synchronizer holds real samples and trig has been seen low,
    // so a trigger held high across reset release cannot start a measurement.
    assign rise     = trig_s & ~trig_d & armed;
    assign fall     = ~trig_s & trig_d;
    assign pre_wrap = (pre_cnt == PRE_LAST);

    // Counters read "cycles since entry minus one" at the fall, so the extra cycle is folded in here.
    assign trig_long = (us_cnt >= MIN_US) || ((us_cnt == MIN_US_M1) && pre_wrap);
    assign accept    = (state == TRIG_HI) && fall && trig_long;

    assign base_w = ((dist_q != 9'd0) && (dist_q <= MAX_D)) ? (16'(dist_q) * 16'd58) : TIMEOUT_W;

`ifdef SONIC_ECHO_EMU_NOISE_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign width_us = base_w + {13'd0, lfsr[2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (accept) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end
`else
    assign width_us = base_w;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (rise) state_n = TRIG_HI;
            TRIG_HI: if (fall) state_n = trig_long ? BURST : IDLE;
            BURST:   if ((us_cnt == BURST_LAST) && pre_wrap) state_n = ECHO;
            ECHO:    if ((us_cnt == width_us - 16'd1) && pre_wrap) state_n = HOLDOFF;
            HOLDOFF: if ((us_cnt == HOLD_LAST) && pre_wrap) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            trig_s1   <= 1'b0;
            trig_s    <= 1'b0;
            trig_d    <= 1'b0;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
            pre_cnt   <= '0;
            us_cnt    <= 16'd0;
            dist_q    <= 9'd0;
            echo      <= 1'b0;
            meas_done <= 1'b0;
            trig_err  <= 1'b0;
        end else begin
            state     <= state_n;
            trig_s1   <= trig;
            trig_s    <= trig_s1;
            trig_d    <= trig_s;
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & ~trig_s);

            // Every state times itself from zero; the us counter saturates for an over-long trigger.
            if ((state_n != state) || (state_n == IDLE)) begin
                pre_cnt <= '0;
                us_cnt  <= 16'd0;
            end else if (pre_wrap) begin
                pre_cnt <= '0;
                if (us_cnt != 16'hFFFF) us_cnt <= us_cnt + 16'd1;
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end

            if (accept) dist_q <= dist_cm;

            echo      <= (state_n == ECHO);
            meas_done <= (state == ECHO) && (state_n == HOLDOFF);
            trig_err  <= (state == TRIG_HI) && fall && !trig_long;
        end
    end

endmodule

// File: doc/sonic_echo_emu.md
SONIC_ECHO_EMU -- requirements
Module: sonic_echo_emu

Interface
REQ-001 Parameter CLK_PER_US, default 100, SHALL be clk cycles per microsecond.
REQ-002 Parameter MIN_TRIG_US, default 10, SHALL be the minimum valid trigger high width in us.
REQ-003 Parameter BURST_US, default 200, SHALL be the delay in us from accepted trigger fall to echo rise.
REQ-004 Parameter MAX_CM, default 400, SHALL be the largest distance answered with a real echo.
REQ-005 Parameter TIMEOUT_US, default 38000, SHALL be the echo width in us for out-of-range distance.
REQ-006 Parameter HOLDOFF_US, default 1000, SHALL be the dead time in us after echo fall.
REQ-007 clk  input  1  system clock (100 MHz nominal).
REQ-008 rst  input  1  reset; synchronous and active-high.
REQ-009 trig  input  1  asynchronous trigger from the sensor controller.
REQ-010 dist_cm  input  9  emulated target distance in cm.
REQ-011 echo  output  1  emulated echo pulse, registered.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 meas_done  output  1  one-cycle pulse on the cycle echo falls.
REQ-014 trig_err  output  1  one-cycle pulse when a trigger shorter than MIN_TRIG_US is rejected.

Function
REQ-015 trig SHALL pass a 2-flop synchronizer; edges SHALL be detected on the synchronized signal (2-cycle input latency).
REQ-016 FSM states SHALL be IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
REQ-017 IDLE -> TRIG_HI on synchronized trig rise; a cycle counter SHALL start at 0 on that cycle.
REQ-018 In TRIG_HI, on synchronized fall: if count >= MIN_TRIG_US*CLK_PER_US go to BURST, else pulse trig_err and return to IDLE.
REQ-019 dist_cm SHALL be latched on the cycle the trigger is accepted; later changes SHALL not affect the measurement.
REQ-020 Echo width W SHALL be dist_cm*58 us when 1 <= dist_cm <= MAX_CM, otherwise TIMEOUT_US us.
REQ-021 echo SHALL rise exactly BURST_US*CLK_PER_US cycles after the acceptance cycle and stay high exactly W*CLK_PER_US cycles.
REQ-022 After echo falls, FSM SHALL remain in HOLDOFF for HOLDOFF_US*CLK_PER_US cycles, then enter IDLE.
REQ-023 Trigger edges in BURST, ECHO or HOLDOFF SHALL be ignored with no error pulse.
REQ-024 A trig held high in IDLE across reset release SHALL not start a measurement; only a fresh rise does.
REQ-025 Time counting SHALL use a 16-bit us counter plus a cycle prescaler; no counter SHALL wrap during a legal measurement.
REQ-026 Width arithmetic SHALL be 16-bit unsigned; MAX_CM*58 SHALL not exceed 65535.

Reset
REQ-027 On rst: state IDLE, echo 0, busy 0, meas_done 0, trig_err 0, synchronizer flops 0, counters 0, latched distance 0.
REQ-028 rst mid-measurement SHALL drop echo on the next clk edge and abandon the measurement with no meas_done.

Configuration
REQ-029 Macro SONIC_ECHO_EMU_NOISE_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on rst) SHALL advance once per accepted trigger and W SHALL become the REQ-020 value plus LFSR[2:0] us (0..7).
REQ-030 Macro undefined: no LFSR; W SHALL be exactly the REQ-020 value.

Verification (CLK_PER_US=100, macro undefined)
REQ-031 trig high 10 us, dist_cm=100 -> echo rises 20000 cycles after acceptance, high 580000 cycles, meas_done one pulse.
REQ-032 trig high 5 us -> trig_err one pulse, echo stays 0, busy low within 3 cycles of fall.
REQ-033 dist_cm=0, then dist_cm=401 -> echo high 3800000 cycles each time.
REQ-034 second 10 us trig during ECHO with dist_cm=39 -> single echo of 226200 cycles, second trig ignored.
REQ-035 rst asserted halfway through ECHO -> echo 0 next cycle, busy 0, no meas_done; next valid trig measures normally.
REQ-036 dist_cm changed 100->20 during BURST -> echo width still 580000 cycles.
